// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-vector accumulate engine.
package mm_pkg;

  // Accumulator group state: no open group / partial sum being built.
  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } acc_state_e;

  // Group-framing sideband travelling alongside each beat through the pipeline.
  typedef struct packed {
    logic first;
    logic last;
  } beat_tag_t;

  // Pipeline depth: one multiply stage plus one register per adder-tree level.
  function automatic int unsigned p_stages(input int unsigned n);
    return 32'd1 + 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mm_dot_lane.sv
// One matrix row: N signed products followed by a registered binary adder tree.
module mm_dot_lane
  import mm_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned ACC_W = 2*DW+8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N*DW-1:0]   row,
  input  logic [N*DW-1:0]   vec,
  output logic [ACC_W-1:0]  sum
);

  localparam int unsigned LVLS = p_stages(N) - 32'd1;
  localparam int unsigned PW   = 2*DW;
  localparam int unsigned EXT  = ACC_W - PW;

  logic [ACC_W-1:0] prod [N];
  // Level 0 holds products; entries past the live node count of a level stay zero,
  // so an unpaired node simply adds zero and passes through its register.
  logic [ACC_W-1:0] node [LVLS+1][2*N];

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'($signed(a)) * PW'($signed(b));
    return {{EXT{p[PW-1]}}, p};
  endfunction

  // Per-column products.
  always_comb begin
    for (int unsigned c = 0; c < N; c++) begin
      prod[c] = mul_ext(row[c*DW +: DW], vec[c*DW +: DW]);
    end
  end

  // Product register and adder-tree levels, all frozen when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= LVLS; k++) begin
        for (int unsigned i = 0; i < 2*N; i++) begin
          node[k][i] <= '0;
        end
      end
    end else if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        node[0][i] <= prod[i];
      end
      for (int unsigned k = 1; k <= LVLS; k++) begin
        for (int unsigned i = 0; i < N; i++) begin
          node[k][i] <= node[k-1][2*i] + node[k-1][2*i+1];
        end
      end
    end
  end

  assign sum = node[LVLS][0];

endmodule

// File: rtl/mm_acc_engine.sv
// Streaming y = A*x engine with per-group accumulation and a global stall.
module mm_acc_engine
  import mm_pkg::*;
#(
  parameter int unsigned M     = 16,
  parameter int unsigned N     = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned ACC_W = 2*DW+8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [M*N*DW-1:0]   in_matrix,
  input  logic [N*DW-1:0]     in_vector,
  input  logic                in_first,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [M*ACC_W-1:0]  out_vector,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         grp_beats
);

  localparam int unsigned P  = p_stages(N);
  localparam int unsigned RW = N*DW;

  logic             rst_done;
  logic             adv;
  logic             accept;
  logic [P-1:0]     stg_vld;
  beat_tag_t        tag [P];
  logic [ACC_W-1:0] lane_sum [M];
  logic [ACC_W-1:0] acc [M];
  logic [ACC_W-1:0] acc_nxt [M];
  acc_state_e       state;
  logic             land;
  logic             land_first;
  logic             land_last;

  // Whole pipeline moves only when the output register can take a result.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_done;
  assign accept   = in_valid && in_ready;

  assign land       = stg_vld[P-1];
  assign land_last  = tag[P-1].last;
  assign land_first = tag[P-1].first || (state == IDLE);

  assign busy = (|stg_vld) || (state == OPEN) || out_valid;

  // Row lanes share the vector and the stall enable.
  for (genvar r = 0; r < M; r++) begin : g_lane
    mm_dot_lane #(
      .N     (N),
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .row   (in_matrix[r*RW +: RW]),
      .vec   (in_vector),
      .sum   (lane_sum[r])
    );
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Beat valid and framing tags ride alongside the lane data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int unsigned i = 0; i < P; i++) tag[i] <= '0;
    end else if (adv) begin
      stg_vld <= {stg_vld[P-2:0], accept};
      tag[0]  <= accept ? beat_tag_t'{first: in_first, last: in_last} : beat_tag_t'('0);
      for (int unsigned i = 1; i < P; i++) tag[i] <= tag[i-1];
    end
  end

  // Next accumulator value: a group start replaces, otherwise adds with wrap.
  always_comb begin
    for (int unsigned r = 0; r < M; r++) begin
      acc_nxt[r] = land_first ? lane_sum[r] : acc[r] + lane_sum[r];
    end
  end

  // Accumulator FSM, beat counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_vector <= '0;
      grp_beats  <= '0;
      for (int unsigned r = 0; r < M; r++) acc[r] <= '0;
    end else if (adv) begin
      out_valid <= land && land_last;
      if (land) begin
        for (int unsigned r = 0; r < M; r++) acc[r] <= acc_nxt[r];
        if (land_first)                grp_beats <= 16'd1;
        else if (grp_beats != 16'hFFFF) grp_beats <= grp_beats + 16'd1;
        state <= land_last ? IDLE : OPEN;
        if (land_last) begin
          for (int unsigned r = 0; r < M; r++) out_vector[r*ACC_W +: ACC_W] <= acc_nxt[r];
        end
      end
    end
  end

endmodule
